// File: rtl/dmem_arbiter_if.sv
// Bundle of core, host and Data_Memory signals around the data-memory arbiter.
// The arbiter takes the slave view; the core/host/memory side takes the master view.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_gnt;
    logic          c_stall;
    logic          c_rvalid;

    logic          h_req;
    logic          h_we;
    logic          h_lock;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          h_gnt;
    logic          h_rvalid;

    logic [DW-1:0] rdata;

    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  h_req, h_we, h_lock, h_addr, h_wdata,
        input  mem_rd,
        output c_gnt, c_stall, c_rvalid,
        output h_gnt, h_rvalid,
        output rdata,
        output mem_a, mem_wd, mem_we
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output h_req, h_we, h_lock, h_addr, h_wdata,
        output mem_rd,
        input  c_gnt, c_stall, c_rvalid,
        input  h_gnt, h_rvalid,
        input  rdata,
        input  mem_a, mem_wd, mem_we
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing single-port Data_Memory between the core (port 0)
// and a host/debug loader (port 1), with a bounded host lock and registered read return.
//
// state | meaning
// IDLE  | no grant was made last cycle
// CORE  | core owned last cycle's grant
// HOST  | host owned last cycle's grant (lock may continue from here)
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic            clk,
    input  logic            rst_l,
    dmem_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

    typedef enum logic [1:0] {IDLE, CORE, HOST} state_t;

    state_t        state;
    logic          last_owner;
    logic          lock_q;
    logic [CW-1:0] lock_cnt;
    logic [AW-1:0] a_q;
    logic [DW-1:0] wd_q;
    logic [DW-1:0] rdata_q;
    logic          c_rv_q;
    logic          h_rv_q;

    logic          lock_act;
    logic          c_gnt;
    logic          h_gnt;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic          mem_we;

    always_comb begin
        lock_act = (state == HOST) && lock_q && bus.h_req && (lock_cnt < LOCK_MAX);
        c_gnt    = 1'b0;
        h_gnt    = 1'b0;
        if (!rst_l) begin
            c_gnt = 1'b0;
            h_gnt = 1'b0;
        end else if (lock_act) begin
            h_gnt = 1'b1;
        end else if (bus.c_req && bus.h_req) begin
            // last_owner is 1 out of reset, so the core wins the first tie
            c_gnt = last_owner;
            h_gnt = ~last_owner;
        end else begin
            c_gnt = bus.c_req;
            h_gnt = bus.h_req;
        end
    end

    always_comb begin
        mem_a  = a_q;
        mem_wd = wd_q;
        mem_we = 1'b0;
        if (h_gnt) begin
            mem_a  = bus.h_addr;
            mem_wd = bus.h_wdata;
            mem_we = bus.h_we;
        end else if (c_gnt) begin
            mem_a  = bus.c_addr;
            mem_wd = bus.c_wdata;
            mem_we = bus.c_we;
        end
    end

    assign bus.c_gnt    = c_gnt;
    assign bus.h_gnt    = h_gnt;
    assign bus.c_stall  = bus.c_req & ~c_gnt;
    assign bus.mem_a    = mem_a;
    assign bus.mem_wd   = mem_wd;
    assign bus.mem_we   = mem_we;
    assign bus.rdata    = rdata_q;
    assign bus.c_rvalid = c_rv_q;
    assign bus.h_rvalid = h_rv_q;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            lock_q     <= 1'b0;
            lock_cnt   <= '0;
            a_q        <= '0;
            wd_q       <= '0;
            rdata_q    <= '0;
            c_rv_q     <= 1'b0;
            h_rv_q     <= 1'b0;
        end else begin
            if (h_gnt)      state <= HOST;
            else if (c_gnt) state <= CORE;
            else            state <= IDLE;

            if (c_gnt || h_gnt) begin
                last_owner <= h_gnt;
                a_q        <= mem_a;
                wd_q       <= mem_wd;
            end

            lock_q <= h_gnt & bus.h_lock;

            // saturates so an uncontested lock can run past the bound
            if (h_gnt && bus.h_lock) begin
                if (lock_cnt != LOCK_MAX)
                    lock_cnt <= lock_cnt + CW'(1);
            end else begin
                lock_cnt <= '0;
            end

            c_rv_q <= c_gnt & ~bus.c_we;
            h_rv_q <= h_gnt & ~bus.h_we;
            if ((c_gnt && !bus.c_we) || (h_gnt && !bus.h_we))
                rdata_q <= bus.mem_rd;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed cycles push hand-derived expected
// outputs; a negedge monitor pops and compares whenever the arbiter shows activity.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(8)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic        cg, hg, st, we;
        logic [31:0] a, wd;
        logic        cv, hv;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_rst = 1'b0;

    logic        p_cv = 1'b0, p_hv = 1'b0;
    logic [31:0] m_rdata = '0, m_a = '0, m_wd = '0;

    always @(posedge clk) cyc++;

    task automatic step(input logic rst,
                        input logic creq, input logic cwe, input logic [31:0] ca, input logic [31:0] cwd,
                        input logic hreq, input logic hwe, input logic hlock, input logic [31:0] ha, input logic [31:0] hwd,
                        input logic [31:0] rd, input logic ecg, input logic ehg);
        exp_t e;
        @(posedge clk);
        #1;
        rst_l       = rst;
        bus.c_req   = creq;  bus.c_we = cwe;  bus.c_addr = ca;  bus.c_wdata = cwd;
        bus.h_req   = hreq;  bus.h_we = hwe;  bus.h_lock = hlock;
        bus.h_addr  = ha;    bus.h_wdata = hwd;
        bus.mem_rd  = rd;
        if (!rst) begin
            p_cv = 1'b0; p_hv = 1'b0; m_rdata = '0; m_a = '0; m_wd = '0;
        end else begin
            e.cyc = cyc;
            e.cg  = ecg;
            e.hg  = ehg;
            e.st  = creq & ~ecg;
            e.we  = (ecg & cwe) | (ehg & hwe);
            if (ecg)      begin m_a = ca; m_wd = cwd; end
            else if (ehg) begin m_a = ha; m_wd = hwd; end
            e.a   = m_a;
            e.wd  = m_wd;
            e.cv  = p_cv;
            e.hv  = p_hv;
            e.rd  = m_rdata;
            if (e.cg || e.hg || e.cv || e.hv || e.we) sb.push_back(e);
            p_cv = ecg & ~cwe;
            p_hv = ehg & ~hwe;
            if ((ecg && !cwe) || (ehg && !hwe)) m_rdata = rd;
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_l) begin
            checks++;
            if (bus.c_gnt || bus.h_gnt || bus.mem_we || (bus.c_stall !== bus.c_req)) begin
                errors++;
                $display("FAIL reset_outs cyc=%0d got cg=%b hg=%b we=%b stall=%b want 0 0 0 stall=%b",
                         cyc, bus.c_gnt, bus.h_gnt, bus.mem_we, bus.c_stall, bus.c_req);
            end
            if (prev_rst) begin
                checks++;
                if (bus.c_rvalid || bus.h_rvalid || bus.rdata != 32'h0) begin
                    errors++;
                    $display("FAIL reset_regs cyc=%0d got cv=%b hv=%b rdata=%h want 0 0 0",
                             cyc, bus.c_rvalid, bus.h_rvalid, bus.rdata);
                end
            end
        end else if (bus.c_gnt || bus.h_gnt || bus.c_rvalid || bus.h_rvalid || bus.mem_we) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got cg=%b hg=%b cv=%b hv=%b we=%b want no activity",
                         cyc, bus.c_gnt, bus.h_gnt, bus.c_rvalid, bus.h_rvalid, bus.mem_we);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || bus.c_gnt !== e.cg || bus.h_gnt !== e.hg || bus.c_stall !== e.st ||
                    bus.mem_we !== e.we || bus.c_rvalid !== e.cv || bus.h_rvalid !== e.hv ||
                    ((e.cg || e.hg) && (bus.mem_a !== e.a || bus.mem_wd !== e.wd)) ||
                    ((e.cv || e.hv) && bus.rdata !== e.rd)) begin
                    errors++;
                    $display("FAIL event cyc=%0d got cg=%b hg=%b st=%b we=%b a=%h wd=%h cv=%b hv=%b rd=%h want cyc=%0d cg=%b hg=%b st=%b we=%b a=%h wd=%h cv=%b hv=%b rd=%h",
                             cyc, bus.c_gnt, bus.h_gnt, bus.c_stall, bus.mem_we, bus.mem_a, bus.mem_wd,
                             bus.c_rvalid, bus.h_rvalid, bus.rdata,
                             e.cyc, e.cg, e.hg, e.st, e.we, e.a, e.wd, e.cv, e.hv, e.rd);
                end
            end
        end
        prev_rst = !rst_l;
    end

    initial begin
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
        bus.h_req = 0; bus.h_we = 0; bus.h_lock = 0; bus.h_addr = 0; bus.h_wdata = 0;
        bus.mem_rd = 0;

        step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // core read, then its rvalid
        step(1'b1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0);
        idle();
        // host write, no rvalid afterwards
        step(1'b1, 0, 0, 0, 0, 1, 1, 0, 32'h20, 32'h55, 0, 0, 1);
        idle();

        // contention from reset: core, host, core, host
        step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            step(1'b1, 1, 0, 32'h30, 0, 1, 0, 0, 32'h34, 0, 32'h100 + k, (k % 2) == 0, (k % 2) == 1);
        idle();

        // lock bound: core write makes core last owner, then host wins and locks for 8
        step(1'b1, 1, 1, 32'h44, 32'h77, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 8; k++)
            step(1'b1, 1, 0, 32'h40, 0, 1, 1, 1, 32'h80 + k, k, 0, 0, 1);
        step(1'b1, 1, 0, 32'h40, 0, 1, 1, 1, 32'h88, 32'h8, 32'h12345678, 1, 0);
        // host relocks: 1st, 2nd, 3rd locked grants
        step(1'b1, 0, 0, 0, 0, 1, 1, 1, 32'h88, 32'h8, 0, 0, 1);
        step(1'b1, 1, 0, 32'h40, 0, 1, 1, 1, 32'h8C, 32'h9, 0, 0, 1);
        step(1'b1, 1, 0, 32'h40, 0, 1, 0, 1, 32'h90, 0, 32'hAAAA0001, 0, 1);
        // reset on the 4th locked grant
        step(1'b0, 1, 0, 32'h40, 0, 1, 0, 1, 32'h90, 0, 0, 0, 0);
        step(1'b0, 1, 0, 32'h40, 0, 1, 0, 1, 32'h90, 0, 0, 0, 0);
        // after release the core wins the first tie
        step(1'b1, 1, 0, 32'h50, 0, 1, 0, 0, 32'h54, 0, 32'hB0, 1, 0);
        step(1'b1, 1, 0, 32'h50, 0, 1, 0, 0, 32'h54, 0, 32'hB1, 0, 1);
        step(1'b1, 1, 0, 32'h50, 0, 0, 0, 0, 0, 0, 32'hB2, 1, 0);
        idle();

        for (int k = 0; k < 5; k++) idle();
        @(negedge clk);
        #1;
        checks++;
        if (bus.rdata !== m_rdata || bus.mem_a !== m_a || bus.mem_wd !== m_wd) begin
            errors++;
            $display("FAIL idle_hold got rdata=%h a=%h wd=%h want rdata=%h a=%h wd=%h",
                     bus.rdata, bus.mem_a, bus.mem_wd, m_rdata, m_a, m_wd);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_events got %0d left want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
